timer_share_arb: RTL and testbench

//  Round-robin arbiter that shares one countdown busy-timer between NREQ

---
 rtl/timer_share_arb.sv | 111 +++++++++++
 tb/tb_timer_share_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_arb.sv
// timer_share_arb: round-robin arbiter sharing one countdown busy-timer between NREQ requesters
module timer_share_arb #(
  parameter int NREQ     = 4,
  parameter int LGNREQ   = 2,
  parameter int WAIT_MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req,
  output logic [NREQ-1:0]   o_grant,
  output logic [LGNREQ-1:0] o_owner,
  output logic              o_timer_start,
  input  logic              i_timer_busy,
  output logic [NREQ-1:0]   o_done,
  output logic              o_error
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_MAX - 1);
  localparam logic [LGNREQ:0] NMOD = (LGNREQ+1)'(NREQ);
  logic [2:0]        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [LGNREQ-1:0] owner_q, owner_d, ptr_q, ptr_d;
  logic              start_q, start_d, error_q, error_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [NREQ-1:0]   rot;
  logic [LGNREQ-1:0] off, win;
  logic [LGNREQ:0]   sum;
  logic              any;
  // winner search: rotate requests so ptr sits at bit 0, take the lowest set bit
  always_comb begin
    rot = NREQ'({i_req, i_req} >> ptr_q);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) off = LGNREQ'(k);
    any = |i_req;
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = (sum >= NMOD) ? LGNREQ'(sum - NMOD) : sum[LGNREQ-1:0];
  end
  // next-state and registered-output logic; start only when the shared timer is idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    error_d = error_q;
    start_d = 1'b0;
    done_d  = '0;
    case (state_q)
      S_IDLE: if (any && !i_timer_busy) begin
        state_d = S_START;
        grant_d = NREQ'(1) << win;
        owner_d = win;
        start_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: if (i_timer_busy) state_d = S_RUN;
        else if (wcnt_q == WLAST) begin
          state_d = S_DONE;
          error_d = 1'b1;
          done_d  = grant_q;
        end else wcnt_d = wcnt_q + 1'b1;
      S_RUN: if (!i_timer_busy) begin
        state_d = S_DONE;
        done_d  = grant_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        owner_d = '0;
        ptr_d   = (owner_q == LGNREQ'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      error_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end
  assign o_grant       = grant_q;
  assign o_owner       = owner_q;
  assign o_timer_start = start_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
endmodule

// File: tb/tb_timer_share_arb.sv
// tb_timer_share_arb: directed bench for timer_share_arb with a 21-cycle busy timer model
module tb_timer_share_arb;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant, done;
  logic [1:0] owner;
  logic       start, busy, error;
  logic [4:0] tcnt = '0;
  logic       force0 = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  timer_share_arb #(.NREQ(4), .LGNREQ(2), .WAIT_MAX(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .o_grant(grant), .o_owner(owner),
    .o_timer_start(start), .i_timer_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  // timer model: not reset by rst; force0 models a dead timer that never goes busy
  always @(posedge clk)
    if (force0) tcnt <= '0;
    else if (start) tcnt <= 5'd21;
    else if (tcnt != 0) tcnt <= tcnt - 5'd1;
  assign busy = !force0 && (tcnt != 0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok, output int n);
    ok = 0;
    n = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (start) ok = 1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok, output int n);
    ok = 0;
    n = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (done != 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick();
    n_cmp++; if ({grant, owner, start, done, error} !== 15'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {grant, owner, start, done, error}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL single_start_c1: got %b want 1", start); end
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant_c1: got %b want 0100", grant); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL single_owner_c1: got %0d want 2", owner); end
    tick();
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_start_c2: got %b want 0", start); end
    for (int c = 3; c <= 23; c++) tick();
    n_cmp++; if (done !== 4'b0000) begin n_bad++; $display("FAIL single_done_c23: got %b want 0000", done); end
    tick();
    n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL single_done_c24: got %b want 0100", done); end
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant_c24: got %b want 0100", grant); end
    req = '0;
    tick();
    n_cmp++; if ({grant, owner, done} !== 10'd0) begin n_bad++; $display("FAIL single_idle_c25: got %h want 0", {grant, owner, done}); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int n;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(60, ok, n);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_start_%0d: got timeout want start", i); end
      n_cmp++; if (owner !== 2'(i % 4)) begin n_bad++; $display("FAIL rr_owner_%0d: got %0d want %0d", i, owner, i % 4); end
      n_cmp++; if (grant !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, grant, 4'(1 << (i % 4))); end
      n_cmp++; if (n !== (i == 0 ? 1 : 2)) begin n_bad++; $display("FAIL rr_gap_%0d: got %0d want %0d", i, n, i == 0 ? 1 : 2); end
      wait_done(60, ok, n);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_done_%0d: got timeout want done", i); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_ptr_order();
    bit ok;
    int n;
    do_reset();
    req = 4'b0001;
    wait_start(60, ok, n);
    wait_done(60, ok, n);
    req = 4'b0011;
    wait_start(60, ok, n);
    n_cmp++; if (!ok || owner !== 2'd1) begin n_bad++; $display("FAIL ptr_first: got ok=%0d owner=%0d want owner 1", ok, owner); end
    wait_done(60, ok, n);
    n_cmp++; if (done !== 4'b0010) begin n_bad++; $display("FAIL ptr_done1: got %b want 0010", done); end
    req = 4'b0001;
    wait_start(60, ok, n);
    n_cmp++; if (!ok || owner !== 2'd0) begin n_bad++; $display("FAIL ptr_second: got ok=%0d owner=%0d want owner 0", ok, owner); end
    wait_done(60, ok, n);
    req = '0;
    tick();
  endtask

  task automatic test_error();
    bit ok;
    int n;
    do_reset();
    force0 = 1'b1;
    req = 4'b0100;
    tick();
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL err_start: got %b want 1", start); end
    tick();
    tick();
    tick();
    n_cmp++; if ({error, done} !== 5'd0) begin n_bad++; $display("FAIL err_early_c4: got %b want 00000", {error, done}); end
    tick();
    n_cmp++; if (done !== 4'b0100) begin n_bad++; $display("FAIL err_done_c5: got %b want 0100", done); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL err_set_c5: got %b want 1", error); end
    req = 4'b0001;
    tick();
    n_cmp++; if ({grant, error} !== 5'b00001) begin n_bad++; $display("FAIL err_idle_c6: got %b want 00001", {grant, error}); end
    force0 = 1'b0;
    tick();
    n_cmp++; if ({start, owner, error} !== 4'b1001) begin n_bad++; $display("FAIL err_regrant_c7: got %b want 1001", {start, owner, error}); end
    wait_done(60, ok, n);
    n_cmp++; if (!ok || error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got ok=%0d error=%b want error 1", ok, error); end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int n;
    int bad_starts;
    do_reset();
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_clears_error: got %b want 0", error); end
    req = 4'b0010;
    wait_start(60, ok, n);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if ({grant, owner, start, done, error} !== 15'd0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", {grant, owner, start, done, error}); end
    rst = 1'b0;
    bad_starts = 0;
    n = 0;
    while (busy && n < 40) begin
      if (start) bad_starts++;
      tick();
      n++;
    end
    n_cmp++; if (bad_starts !== 0 || busy !== 1'b0 || start !== 1'b0) begin n_bad++; $display("FAIL rst_stale_hold: got starts=%0d busy=%b start=%b want 0 0 0", bad_starts, busy, start); end
    tick();
    n_cmp++; if ({start, owner} !== 3'b101) begin n_bad++; $display("FAIL rst_resume: got %b want 101", {start, owner}); end
    wait_done(60, ok, n);
    req = '0;
    tick();
  endtask

  task automatic test_drop_mid_run();
    bit ok;
    int n;
    req = 4'b1000;
    wait_start(60, ok, n);
    n_cmp++; if (!ok || owner !== 2'd3) begin n_bad++; $display("FAIL drop_owner: got ok=%0d owner=%0d want owner 3", ok, owner); end
    for (int c = 0; c < 5; c++) tick();
    req = 4'b0001;
    wait_done(60, ok, n);
    n_cmp++; if (!ok || done !== 4'b1000) begin n_bad++; $display("FAIL drop_done: got ok=%0d done=%b want 1000", ok, done); end
    wait_start(60, ok, n);
    n_cmp++; if (!ok || n !== 2 || owner !== 2'd0) begin n_bad++; $display("FAIL drop_next: got ok=%0d gap=%0d owner=%0d want gap 2 owner 0", ok, n, owner); end
    wait_done(60, ok, n);
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_order();
    test_error();
    test_reset_mid_run();
    test_drop_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
